// File: rtl/imdct_axi_ctrl_if.sv
// AXI4-Lite register-port bundle for the IMDCT control block.
// Latency: none (wires only).
// Backpressure: carries the standard valid/ready pairs of all five AXI-Lite channels.
// Ports: AW (awaddr/awprot/awvalid/awready), W (wdata/wstrb/wvalid/wready),
//        B (bresp/bvalid/bready), AR (araddr/arprot/arvalid/arready),
//        R (rdata/rresp/rvalid/rready). The slave modport is the register block side.
interface imdct_axi_ctrl_if #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
) ();
   logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr;
   logic [2:0]                        s_axi_awprot;
   logic                              s_axi_awvalid;
   logic                              s_axi_awready;
   logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata;
   logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb;
   logic                              s_axi_wvalid;
   logic                              s_axi_wready;
   logic [1:0]                        s_axi_bresp;
   logic                              s_axi_bvalid;
   logic                              s_axi_bready;
   logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr;
   logic [2:0]                        s_axi_arprot;
   logic                              s_axi_arvalid;
   logic                              s_axi_arready;
   logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata;
   logic [1:0]                        s_axi_rresp;
   logic                              s_axi_rvalid;
   logic                              s_axi_rready;

   modport slave (
      input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
      output s_axi_awready,
      input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
      output s_axi_wready,
      output s_axi_bresp, s_axi_bvalid,
      input  s_axi_bready,
      input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
      output s_axi_arready,
      output s_axi_rdata, s_axi_rresp, s_axi_rvalid,
      input  s_axi_rready
   );

   modport master (
      output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
      input  s_axi_awready,
      output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
      input  s_axi_wready,
      input  s_axi_bresp, s_axi_bvalid,
      output s_axi_bready,
      output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
      input  s_axi_arready,
      input  s_axi_rdata, s_axi_rresp, s_axi_rvalid,
      output s_axi_rready
   );
endinterface

// File: rtl/imdct_axi_ctrl.sv
// AXI4-Lite control/status registers for the IMDCT core: start pulse, run FSM, sticky status.
// Latency: write takes effect the cycle after AW and W are both latched, bvalid one cycle later; rdata 1 cycle after AR.
// Backpressure: AW/W stall while a response is pending in B; AR stalls while R holds unaccepted data.
// Ports: clock, reset (sync, active-high), s_axi (slave modport of imdct_axi_ctrl_if),
//        core_start (1-cycle pulse), core_ready (core idle), core_block_type (registered BTYPE),
//        irq (only when IMDCT_IRQ_EN is defined: done & IRQEN.bit0, level).
// Map (word index): 0 CTRL, 1 STATUS (W1C bits 1-2), 2 BTYPE, 3 RUNCNT, 4 IRQEN or 0, 5-7 read 0.
module imdct_axi_ctrl #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
) (
   input  logic                 clock,
   input  logic                 reset,
   imdct_axi_ctrl_if.slave      s_axi,
   output logic                 core_start,
   input  logic                 core_ready,
   output logic [1:0]           core_block_type
`ifdef IMDCT_IRQ_EN
   ,
   output logic                 irq
`endif
);
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT_BUSY, ST_RUN, ST_DONE} state_t;

   state_t                          state_q;
   logic                            core_start_q;
   logic [1:0]                      btype_q;
   logic                            done_q, err_q;
   logic [31:0]                     runcnt_q;
`ifdef IMDCT_IRQ_EN
   logic                            irqen_q;
`endif

   // Channel state (registered handshake outputs keep all readies low in reset).
   logic                            awready_q, awready_d, wready_q, wready_d;
   logic                            aw_vld_q, aw_vld_d, w_vld_q, w_vld_d;
   logic [C_S_AXI_ADDR_WIDTH-3:0]   aw_idx_q, aw_idx_d;
   logic [2:0]                      w_dat_q, w_dat_d;
   logic                            w_strb_q, w_strb_d;
   logic                            bvalid_q, bvalid_d;
   logic                            arready_q, arready_d, rvalid_q, rvalid_d;
   logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;

   logic aw_hs, w_hs, ar_hs, do_write;
   logic start_req, w1c_done, w1c_err, btype_wr;
   logic unused_bits;

   assign aw_hs    = s_axi.s_axi_awvalid & awready_q;
   assign w_hs     = s_axi.s_axi_wvalid  & wready_q;
   assign ar_hs    = s_axi.s_axi_arvalid & arready_q;
   assign do_write = aw_vld_q & w_vld_q;

   // Only the bits the register map needs are latched from the W channel.
   assign start_req = do_write && (aw_idx_q == 3'd0) && w_dat_q[0];
   assign w1c_done  = do_write && (aw_idx_q == 3'd1) && w_dat_q[1];
   assign w1c_err   = do_write && (aw_idx_q == 3'd1) && w_dat_q[2];
   assign btype_wr  = do_write && (aw_idx_q == 3'd2) && w_strb_q;

   always_comb begin
      aw_vld_d = aw_vld_q;
      aw_idx_d = aw_idx_q;
      w_vld_d  = w_vld_q;
      w_dat_d  = w_dat_q;
      w_strb_d = w_strb_q;
      bvalid_d = bvalid_q;
      if (bvalid_q && s_axi.s_axi_bready) bvalid_d = 1'b0;
      if (aw_hs) begin
         aw_vld_d = 1'b1;
         aw_idx_d = s_axi.s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
         w_vld_d  = 1'b1;
         w_dat_d  = s_axi.s_axi_wdata[2:0];
         w_strb_d = s_axi.s_axi_wstrb[0];
      end
      // Both halves present: commit now, response next cycle. Ready cannot be
      // high here (address/data already latched), so no new beat collides.
      if (do_write) begin
         aw_vld_d = 1'b0;
         w_vld_d  = 1'b0;
         bvalid_d = 1'b1;
      end
      awready_d = !aw_vld_d && !bvalid_d;
      wready_d  = !w_vld_d  && !bvalid_d;

      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      if (rvalid_q && s_axi.s_axi_rready) rvalid_d = 1'b0;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = '0;
         case (s_axi.s_axi_araddr[4:2])
            3'd1: rdata_d[2:0] = {err_q, done_q, core_ready};
            3'd2: rdata_d[1:0] = btype_q;
            3'd3: rdata_d[31:0] = runcnt_q;
`ifdef IMDCT_IRQ_EN
            3'd4: rdata_d[0] = irqen_q;
`endif
            default: rdata_d = '0;
         endcase
      end
      arready_d = !rvalid_d;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         core_start_q <= 1'b0;
         btype_q      <= 2'd0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         runcnt_q     <= 32'd0;
`ifdef IMDCT_IRQ_EN
         irqen_q      <= 1'b0;
`endif
         awready_q    <= 1'b0;
         wready_q     <= 1'b0;
         aw_vld_q     <= 1'b0;
         aw_idx_q     <= '0;
         w_vld_q      <= 1'b0;
         w_dat_q      <= 3'd0;
         w_strb_q     <= 1'b0;
         bvalid_q     <= 1'b0;
         arready_q    <= 1'b0;
         rvalid_q     <= 1'b0;
         rdata_q      <= '0;
      end else begin
         awready_q    <= awready_d;
         wready_q     <= wready_d;
         aw_vld_q     <= aw_vld_d;
         aw_idx_q     <= aw_idx_d;
         w_vld_q      <= w_vld_d;
         w_dat_q      <= w_dat_d;
         w_strb_q     <= w_strb_d;
         bvalid_q     <= bvalid_d;
         arready_q    <= arready_d;
         rvalid_q     <= rvalid_d;
         rdata_q      <= rdata_d;

         core_start_q <= 1'b0;
         // Clears first; any set later in this block overrides (set wins).
         if (w1c_done) done_q <= 1'b0;
         if (w1c_err)  err_q  <= 1'b0;
`ifdef IMDCT_IRQ_EN
         if (do_write && (aw_idx_q == 3'd4) && w_strb_q) irqen_q <= w_dat_q[0];
`endif
         // Block type must not change under a running core.
         if (btype_wr) begin
            if (state_q == ST_IDLE) btype_q <= w_dat_q[1:0];
            else                    err_q   <= 1'b1;
         end
         if (start_req && (state_q != ST_IDLE)) err_q <= 1'b1;

         case (state_q)
            ST_IDLE: begin
               if (start_req) begin
                  if (core_ready) begin
                     core_start_q <= 1'b1;
                     state_q      <= ST_WAIT_BUSY;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            ST_WAIT_BUSY: if (!core_ready) state_q <= ST_RUN;
            ST_RUN:       if (core_ready)  state_q <= ST_DONE;
            ST_DONE: begin
               done_q   <= 1'b1;
               runcnt_q <= runcnt_q + 32'd1;
               state_q  <= ST_IDLE;
            end
            default:      state_q <= ST_IDLE;
         endcase
      end
   end

   assign s_axi.s_axi_awready = awready_q;
   assign s_axi.s_axi_wready  = wready_q;
   assign s_axi.s_axi_bvalid  = bvalid_q;
   assign s_axi.s_axi_bresp   = 2'b00;
   assign s_axi.s_axi_arready = arready_q;
   assign s_axi.s_axi_rvalid  = rvalid_q;
   assign s_axi.s_axi_rdata   = rdata_q;
   assign s_axi.s_axi_rresp   = 2'b00;

   assign core_start      = core_start_q;
   assign core_block_type = btype_q;
`ifdef IMDCT_IRQ_EN
   assign irq = done_q & irqen_q;
`endif

   // Protection bits, byte lanes and data bits beyond the map carry no state.
   assign unused_bits = ^{s_axi.s_axi_awprot, s_axi.s_axi_arprot,
                          s_axi.s_axi_awaddr[1:0], s_axi.s_axi_araddr[1:0],
                          s_axi.s_axi_wdata[C_S_AXI_DATA_WIDTH-1:3],
                          s_axi.s_axi_wstrb[C_S_AXI_DATA_WIDTH/8-1:1]};
endmodule

// File: tb/tb_imdct_axi_ctrl.sv
// Self-checking bench for imdct_axi_ctrl: register table, core run sequences, backpressure, reset mid-run.
// Latency: n/a (bench).
// Backpressure: exercises held bready/rready; read expectations queued at AR issue, compared at R handshake.
module tb_imdct_axi_ctrl;
   logic clock;
   logic reset;
   logic core_start;
   logic core_ready;
   logic [1:0] core_block_type;
`ifdef IMDCT_IRQ_EN
   logic irq;
   localparam logic [31:0] REG4_RB = 32'h1;
`else
   localparam logic [31:0] REG4_RB = 32'h0;
`endif

   imdct_axi_ctrl_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) axi ();

   imdct_axi_ctrl #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
      .clock           (clock),
      .reset           (reset),
      .s_axi           (axi.slave),
      .core_start      (core_start),
      .core_ready      (core_ready),
      .core_block_type (core_block_type)
`ifdef IMDCT_IRQ_EN
      ,
      .irq             (irq)
`endif
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;
   logic [1:0] last_bt = 2'd0;
   logic [31:0] exp_q[$];
   string       tag_q[$];

   // Counts every cycle core_start is high, so a stretched pulse shows up as an extra start.
   always @(negedge clock) begin
      if (core_start) begin
         start_cnt = start_cnt + 1;
         last_bt   = core_block_type;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks = checks + 1;
      if (act !== req) begin
         errors = errors + 1;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_d, input int w_d, input int b_hold, input string name);
      logic aw_done, w_done, aw_hit, w_hit, hold_bad;
      int   cyc;
      aw_done = 1'b0;
      w_done  = 1'b0;
      axi.s_axi_awaddr = addr;
      axi.s_axi_wdata  = data;
      axi.s_axi_wstrb  = strb;
      axi.s_axi_bready = (b_hold == 0);
      cyc = 0;
      while (cyc < 40 && !(aw_done && w_done)) begin
         if (cyc == aw_d) axi.s_axi_awvalid = 1'b1;
         if (cyc == w_d)  axi.s_axi_wvalid  = 1'b1;
         aw_hit = axi.s_axi_awvalid && axi.s_axi_awready;
         w_hit  = axi.s_axi_wvalid  && axi.s_axi_wready;
         @(negedge clock);
         if (aw_hit) begin axi.s_axi_awvalid = 1'b0; aw_done = 1'b1; end
         if (w_hit)  begin axi.s_axi_wvalid  = 1'b0; w_done  = 1'b1; end
         cyc = cyc + 1;
      end
      axi.s_axi_awvalid = 1'b0;
      axi.s_axi_wvalid  = 1'b0;
      chk({name, "_aw_w_accepted"}, {62'd0, aw_done, w_done}, 64'h3);
      cyc = 0;
      while (!axi.s_axi_bvalid && cyc < 20) begin
         @(negedge clock);
         cyc = cyc + 1;
      end
      if (!axi.s_axi_bvalid) begin
         chk({name, "_bvalid_timeout"}, 64'd0, 64'd1);
      end else begin
         hold_bad = 1'b0;
         for (int i = 0; i < b_hold; i++) begin
            if (!axi.s_axi_bvalid || axi.s_axi_awready || axi.s_axi_wready) hold_bad = 1'b1;
            @(negedge clock);
         end
         if (b_hold > 0) chk({name, "_b_hold"}, {63'd0, hold_bad}, 64'd0);
         chk({name, "_bresp"}, {62'd0, axi.s_axi_bresp}, 64'd0);
         axi.s_axi_bready = 1'b1;
         @(negedge clock);
         chk({name, "_bvalid_once"}, {63'd0, axi.s_axi_bvalid}, 64'd0);
      end
      axi.s_axi_bready = 1'b0;
   endtask

   task automatic axi_read(input logic [4:0] addr, input logic [31:0] expv, input string name, input int r_hold);
      int cyc;
      logic [31:0] first;
      logic [31:0] want;
      string tag;
      logic bad;
      exp_q.push_back(expv);
      tag_q.push_back(name);
      axi.s_axi_araddr  = addr;
      axi.s_axi_arvalid = 1'b1;
      axi.s_axi_rready  = 1'b0;
      cyc = 0;
      while (!axi.s_axi_arready && cyc < 20) begin
         @(negedge clock);
         cyc = cyc + 1;
      end
      if (axi.s_axi_arready) begin
         @(negedge clock);
         axi.s_axi_arvalid = 1'b0;
         cyc = 0;
         while (!axi.s_axi_rvalid && cyc < 20) begin
            @(negedge clock);
            cyc = cyc + 1;
         end
      end
      axi.s_axi_arvalid = 1'b0;
      want = exp_q.pop_front();
      tag  = tag_q.pop_front();
      if (!axi.s_axi_rvalid) begin
         chk({tag, "_timeout"}, 64'd0, 64'd1);
      end else begin
         first = axi.s_axi_rdata;
         bad   = 1'b0;
         for (int i = 0; i < r_hold; i++) begin
            if (!axi.s_axi_rvalid || axi.s_axi_rdata !== first) bad = 1'b1;
            @(negedge clock);
         end
         if (r_hold > 0) chk({tag, "_r_hold"}, {63'd0, bad}, 64'd0);
         axi.s_axi_rready = 1'b1;
         chk(tag, {30'd0, axi.s_axi_rresp, axi.s_axi_rdata}, {32'd0, want});
         @(negedge clock);
         axi.s_axi_rready = 1'b0;
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clock);
   endtask

   typedef struct packed {
      logic        wr;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          aw_d;
      int          w_d;
      logic [4:0]  raddr;
      logic [31:0] expv;
   } vec_t;

   vec_t tbl [12];

   initial begin
      #500000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // Register accesses from IDLE with core_ready=1; W-first ordering on some rows.
      tbl[0]  = '{1'b0, 5'h00, 32'h0,        4'h0, 0, 0, 5'h00, 32'h0};
      tbl[1]  = '{1'b1, 5'h08, 32'h3,        4'hF, 0, 0, 5'h08, 32'h3};
      tbl[2]  = '{1'b1, 5'h08, 32'h1,        4'hE, 0, 0, 5'h08, 32'h3};
      tbl[3]  = '{1'b1, 5'h08, 32'hFFFFFFFE, 4'h1, 2, 0, 5'h08, 32'h2};
      tbl[4]  = '{1'b1, 5'h08, 32'h0,        4'hF, 0, 1, 5'h08, 32'h0};
      tbl[5]  = '{1'b0, 5'h00, 32'h0,        4'h0, 0, 0, 5'h0C, 32'h0};
      tbl[6]  = '{1'b1, 5'h14, 32'hFFFFFFFF, 4'hF, 0, 0, 5'h14, 32'h0};
      tbl[7]  = '{1'b1, 5'h1C, 32'h00001234, 4'hF, 1, 0, 5'h18, 32'h0};
      tbl[8]  = '{1'b1, 5'h10, 32'h1,        4'hF, 0, 0, 5'h10, REG4_RB};
      tbl[9]  = '{1'b1, 5'h10, 32'h0,        4'hF, 0, 0, 5'h10, 32'h0};
      tbl[10] = '{1'b1, 5'h00, 32'h0,        4'hF, 0, 0, 5'h04, 32'h1};
      tbl[11] = '{1'b1, 5'h04, 32'hFFFFFFFF, 4'hF, 0, 0, 5'h04, 32'h1};

      reset = 1'b1;
      core_ready = 1'b1;
      axi.s_axi_awaddr = '0; axi.s_axi_awprot = '0; axi.s_axi_awvalid = 1'b0;
      axi.s_axi_wdata = '0;  axi.s_axi_wstrb = '0;  axi.s_axi_wvalid = 1'b0;
      axi.s_axi_bready = 1'b0;
      axi.s_axi_araddr = '0; axi.s_axi_arprot = '0; axi.s_axi_arvalid = 1'b0;
      axi.s_axi_rready = 1'b0;
      cycles(3);
      chk("reset_outputs", {56'd0, axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_bvalid,
          axi.s_axi_arready, axi.s_axi_rvalid, core_start, core_block_type != 2'd0,
          axi.s_axi_rdata != 32'd0}, 64'd0);
      reset = 1'b0;
      cycles(2);

      // 1: STATUS after reset shows only core_ready.
      axi_read(5'h04, 32'h1, "status_after_reset", 0);

      for (int i = 0; i < 12; i++) begin
         if (tbl[i].wr)
            axi_write(tbl[i].waddr, tbl[i].wdata, tbl[i].wstrb, tbl[i].aw_d, tbl[i].w_d, 0,
                      $sformatf("vec%0d_wr", i));
         axi_read(tbl[i].raddr, tbl[i].expv, $sformatf("vec%0d_rd", i), 0);
      end
      chk("no_spurious_start", start_cnt, 0);

      // 2: AW three cycles ahead of W, then a full run.
      axi_write(5'h08, 32'h2, 4'hF, 0, 3, 0, "btype2_aw_first");
      axi_read(5'h08, 32'h2, "btype2_rd", 0);
      axi_write(5'h00, 32'h1, 4'hF, 0, 0, 0, "start1");
      chk("start1_pulse", start_cnt, 1);
      chk("start1_btype", {62'd0, last_bt}, 64'd2);
      core_ready = 1'b0;
      cycles(20);
      chk("btype_port_during_run", {62'd0, core_block_type}, 64'd2);
      core_ready = 1'b1;
      cycles(3);
      axi_read(5'h04, 32'h3, "status_done", 0);
      axi_read(5'h0C, 32'h1, "runcnt_1", 0);

      // 3: start and BTYPE writes while busy are refused and flagged.
      axi_write(5'h00, 32'h1, 4'hF, 0, 0, 0, "start2");
      chk("start2_pulse", start_cnt, 2);
      core_ready = 1'b0;
      cycles(2);
      axi_write(5'h00, 32'h1, 4'hF, 0, 0, 0, "start_busy");
      chk("start_busy_no_pulse", start_cnt, 2);
      axi_read(5'h04, 32'h6, "status_busy_err", 0);
      axi_write(5'h08, 32'h1, 4'hF, 0, 0, 0, "btype_busy");
      axi_read(5'h08, 32'h2, "btype_busy_rd", 0);
      axi_write(5'h04, 32'h4, 4'hF, 0, 0, 0, "w1c_err");
      axi_read(5'h04, 32'h2, "status_err_cleared", 0);
      axi_write(5'h04, 32'h2, 4'hF, 0, 0, 0, "w1c_done");
      axi_read(5'h04, 32'h0, "status_done_cleared", 0);

      // W1C of done lands in the same cycle the FSM sets done: set must win.
      core_ready = 1'b1;
      axi.s_axi_awaddr = 5'h04; axi.s_axi_wdata = 32'h2; axi.s_axi_wstrb = 4'hF;
      axi.s_axi_awvalid = 1'b1; axi.s_axi_wvalid = 1'b1; axi.s_axi_bready = 1'b1;
      @(negedge clock);
      axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0;
      cycles(4);
      axi.s_axi_bready = 1'b0;
      axi_read(5'h04, 32'h3, "status_set_wins", 0);
      axi_read(5'h0C, 32'h2, "runcnt_2", 0);

      // Start in IDLE with the core not ready: dropped and flagged.
      core_ready = 1'b0;
      axi_write(5'h00, 32'h1, 4'hF, 0, 0, 0, "start_not_ready");
      chk("start_not_ready_no_pulse", start_cnt, 2);
      axi_read(5'h04, 32'h6, "status_not_ready_err", 0);
      axi_write(5'h04, 32'h6, 4'hF, 0, 0, 0, "w1c_both");
      axi_read(5'h04, 32'h0, "status_all_cleared", 0);
      core_ready = 1'b1;

      // 4: held bready and rready.
      axi_write(5'h08, 32'h1, 4'hF, 0, 0, 5, "bready_hold");
      axi_read(5'h08, 32'h1, "rready_hold", 5);

      // 5: reset in the middle of a run.
      axi_write(5'h00, 32'h1, 4'hF, 0, 0, 0, "start3");
      chk("start3_pulse", start_cnt, 3);
      chk("start3_btype", {62'd0, last_bt}, 64'd1);
      core_ready = 1'b0;
      cycles(3);
      reset = 1'b1;
      cycles(2);
      chk("reset_midrun_outputs", {58'd0, core_start, axi.s_axi_bvalid, axi.s_axi_rvalid,
          axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready}, 64'd0);
      reset = 1'b0;
      cycles(2);
      chk("no_restart_after_reset", start_cnt, 3);
      axi_read(5'h04, 32'h0, "status_after_midrun_reset", 0);
      axi_read(5'h08, 32'h0, "btype_after_midrun_reset", 0);
      axi_read(5'h0C, 32'h0, "runcnt_after_midrun_reset", 0);
      core_ready = 1'b1;
      cycles(2);
      axi_write(5'h00, 32'h1, 4'hF, 0, 0, 0, "start4");
      chk("start4_pulse", start_cnt, 4);
      core_ready = 1'b0;
      cycles(5);
      core_ready = 1'b1;
      cycles(3);
      axi_read(5'h0C, 32'h1, "runcnt_after_restart", 0);
      axi_read(5'h04, 32'h3, "status_after_restart", 0);

`ifdef IMDCT_IRQ_EN
      // 6: level interrupt gated by IRQEN, dropped by W1C of done.
      chk("irq_masked", {63'd0, irq}, 64'd0);
      axi_write(5'h10, 32'h1, 4'hF, 0, 0, 0, "irqen_set");
      chk("irq_asserted", {63'd0, irq}, 64'd1);
      axi_write(5'h04, 32'h2, 4'hF, 0, 0, 0, "irq_w1c");
      chk("irq_cleared", {63'd0, irq}, 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
